// File: rtl/mbscore_alu_mdu.sv
// rtl/mbscore_alu_mdu.sv - execute-stage ALU with iterative multiply/divide; divider guarded by MBSCORE_ALU_MDU_DIV_EN
module mbscore_alu_mdu #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [OP_WIDTH-1:0]   i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_cf,
  output logic                  o_of,
  output logic                  o_zf,
  output logic                  o_busy
);

  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH);

  localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_ADDU  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_SUBU  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_AND   = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_OR    = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_XOR   = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_NOR   = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_SLL   = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_SRL   = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] OP_SRA   = OP_WIDTH'(10);
  localparam logic [OP_WIDTH-1:0] OP_EQ    = OP_WIDTH'(11);
  localparam logic [OP_WIDTH-1:0] OP_NE    = OP_WIDTH'(12);
  localparam logic [OP_WIDTH-1:0] OP_LT    = OP_WIDTH'(13);
  localparam logic [OP_WIDTH-1:0] OP_LTU   = OP_WIDTH'(14);
  localparam logic [OP_WIDTH-1:0] OP_MUL   = OP_WIDTH'(15);
  localparam logic [OP_WIDTH-1:0] OP_MULH  = OP_WIDTH'(16);
  localparam logic [OP_WIDTH-1:0] OP_MULHU = OP_WIDTH'(17);
`ifdef MBSCORE_ALU_MDU_DIV_EN
  localparam logic [OP_WIDTH-1:0] OP_DIV   = OP_WIDTH'(18);
  localparam logic [OP_WIDTH-1:0] OP_DIVU  = OP_WIDTH'(19);
  localparam logic [OP_WIDTH-1:0] OP_REM   = OP_WIDTH'(20);
  localparam logic [OP_WIDTH-1:0] OP_REMU  = OP_WIDTH'(21);
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t              r_state, w_next_state;
  logic [SW-1:0]       r_cnt;
  logic [2*W-1:0]      r_acc;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [W-1:0]        r_dvs;      // multiplicand or divisor magnitude
  logic [OP_WIDTH-1:0] r_op;
  logic                r_neg;      // product / quotient must be negated in FIX
`ifdef MBSCORE_ALU_MDU_DIV_EN
  logic                r_neg_r;    // remainder takes the dividend's sign
  logic                r_div0;
  logic [W:0]          w_trial;
`endif

  logic                w_accept, w_mul_op, w_div_op, w_iter, w_sgn, w_a_neg, w_b_neg;
  logic                w_r_mul, w_out_free, w_load_fix, w_load;
  logic [W-1:0]        w_a_mag, w_b_mag, w_sc_res, w_fix_res, w_load_res;
  logic                w_sc_cf, w_sc_of;
  logic [W:0]          w_sum, w_diff, w_mul_sum;
  logic [2*W-1:0]      w_acc_step, w_prod;
  logic [SW-1:0]       w_shamt;

  assign o_busy     = (r_state != S_IDLE);
  assign w_out_free = !o_out_valid || i_out_ready;
  assign o_in_ready = (r_state == S_IDLE) && w_out_free;
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_mul_op   = (i_op == OP_MUL) || (i_op == OP_MULH) || (i_op == OP_MULHU);
  assign w_r_mul    = (r_op == OP_MUL) || (r_op == OP_MULH) || (r_op == OP_MULHU);
`ifdef MBSCORE_ALU_MDU_DIV_EN
  assign w_div_op   = (i_op == OP_DIV) || (i_op == OP_DIVU) || (i_op == OP_REM) || (i_op == OP_REMU);
  assign w_sgn      = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
`else
  assign w_div_op   = 1'b0;
  assign w_sgn      = (i_op == OP_MULH);
`endif
  assign w_iter     = w_mul_op || w_div_op;
  assign w_a_neg    = w_sgn && i_a[W-1];
  assign w_b_neg    = w_sgn && i_b[W-1];
  assign w_a_mag    = w_a_neg ? -i_a : i_a;
  assign w_b_mag    = w_b_neg ? -i_b : i_b;
  assign w_load_fix = (r_state == S_FIX) && w_out_free;
  assign w_load     = w_load_fix || (w_accept && !w_iter);
  assign w_load_res = w_load_fix ? w_fix_res : w_sc_res;
  assign w_shamt    = i_a[SW-1:0];

  // Single-cycle result and flags
  always_comb begin
    w_sc_res = '0;
    w_sc_cf  = 1'b0;
    w_sc_of  = 1'b0;
    w_sum    = {1'b0, i_a} + {1'b0, i_b};
    w_diff   = {1'b0, i_a} - {1'b0, i_b};
    case (i_op)
      OP_ADD: begin
        w_sc_res = w_sum[W-1:0];
        w_sc_cf  = w_sum[W];
        w_sc_of  = (i_a[W-1] == i_b[W-1]) && (w_sum[W-1] != i_a[W-1]);
      end
      OP_ADDU: w_sc_res = w_sum[W-1:0];
      OP_SUB: begin
        w_sc_res = w_diff[W-1:0];
        w_sc_cf  = w_diff[W];
        w_sc_of  = (i_a[W-1] != i_b[W-1]) && (w_diff[W-1] != i_a[W-1]);
      end
      OP_SUBU: w_sc_res = w_diff[W-1:0];
      OP_AND:  w_sc_res = i_a & i_b;
      OP_OR:   w_sc_res = i_a | i_b;
      OP_XOR:  w_sc_res = i_a ^ i_b;
      OP_NOR:  w_sc_res = ~(i_a | i_b);
      OP_SLL:  w_sc_res = i_b << w_shamt;
      OP_SRL:  w_sc_res = i_b >> w_shamt;
      OP_SRA:  w_sc_res = W'($signed(i_b) >>> w_shamt);
      OP_EQ:   w_sc_res = W'(i_a == i_b);
      OP_NE:   w_sc_res = W'(i_a != i_b);
      OP_LT:   w_sc_res = W'($signed(i_a) < $signed(i_b));
      OP_LTU:  w_sc_res = W'(i_a < i_b);
      default: w_sc_res = '0;
    endcase
  end

  // One shift-add or restoring-division step per RUN cycle
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_dvs} : '0);
    w_acc_step = {w_mul_sum, r_acc[W-1:1]};
`ifdef MBSCORE_ALU_MDU_DIV_EN
    w_trial = {r_acc[2*W-1:W], r_acc[W-1]} - {1'b0, r_dvs};
    if (!w_r_mul) begin
      if (!w_trial[W]) w_acc_step = {w_trial[W-1:0], r_acc[W-2:0], 1'b1};
      else             w_acc_step = {r_acc[2*W-2:0], 1'b0};
    end
`endif
  end

  // Sign correction and half selection for the iterative result
  always_comb begin
    w_prod    = r_neg ? -r_acc : r_acc;
    w_fix_res = '0;
    case (r_op)
      OP_MUL:            w_fix_res = w_prod[W-1:0];
      OP_MULH, OP_MULHU: w_fix_res = w_prod[2*W-1:W];
`ifdef MBSCORE_ALU_MDU_DIV_EN
      OP_DIV, OP_DIVU:   w_fix_res = r_div0 ? '1 : (r_neg ? -r_acc[W-1:0] : r_acc[W-1:0]);
      OP_REM, OP_REMU:   w_fix_res = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
`endif
      default:           w_fix_res = '0;
    endcase
  end

  // Next-state logic: IDLE -> RUN -> FIX -> IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_iter) w_next_state = S_RUN;
      S_RUN:   if (r_cnt == '0) w_next_state = S_FIX;
      S_FIX:   if (w_out_free) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Iterative datapath: load operand magnitudes on accept, step while RUN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_dvs   <= '0;
      r_op    <= '0;
      r_neg   <= 1'b0;
`ifdef MBSCORE_ALU_MDU_DIV_EN
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
`endif
    end else if (w_accept && w_iter) begin
      r_cnt   <= SW'(W - 1);
      r_acc   <= {{W{1'b0}}, w_a_mag};
      r_dvs   <= w_b_mag;
      r_op    <= i_op;
      r_neg   <= w_a_neg ^ w_b_neg;
`ifdef MBSCORE_ALU_MDU_DIV_EN
      r_neg_r <= w_a_neg;
      r_div0  <= (i_b == '0);
`endif
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc_step;
      r_cnt <= r_cnt - SW'(1);
    end
  end

  // Output register: load wins over drain; held while stalled
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_out_valid <= 1'b0;
      o_result    <= '0;
      o_cf        <= 1'b0;
      o_of        <= 1'b0;
      o_zf        <= 1'b0;
    end else if (w_load) begin
      o_out_valid <= 1'b1;
      o_result    <= w_load_res;
      o_cf        <= w_load_fix ? 1'b0 : w_sc_cf;
      o_of        <= w_load_fix ? 1'b0 : w_sc_of;
      o_zf        <= (w_load_res == '0);
    end else if (i_out_ready) begin
      o_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mbscore_alu_mdu.sv
// tb/tb_mbscore_alu_mdu.sv - directed self-checking bench for mbscore_alu_mdu
module tb_mbscore_alu_mdu;

  localparam logic [4:0] ADD = 0, ADDU = 1, SUB = 2, NOR = 7, SLL = 8, SRL = 9, SRA = 10;
  localparam logic [4:0] EQ = 11, NE = 12, LT = 13, LTU = 14, MUL = 15, MULH = 16, MULHU = 17;
  localparam logic [4:0] DIV = 18, DIVU = 19, REM = 20, REMU = 21;

  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, cf, of_, zf, busy;
  logic [4:0]  op = '0;
  logic [31:0] a = '0, b = '0, result;

  int n_total = 0, n_bad = 0;
  int lat, busy_cnt;
  logic rdy_seen, flag;
  logic [31:0] hold_res;

  always #5 clk = ~clk;

  mbscore_alu_mdu #(.DATA_WIDTH(32), .OP_WIDTH(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_op(op), .i_a(a), .i_b(b), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_result(result), .o_cf(cf), .o_of(of_), .o_zf(zf), .o_busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Offer one op, wait (bounded) for its result; lat counts edges after the accept edge
  task automatic do_op(input logic [4:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i);
    @(negedge clk);
    op = op_i; a = a_i; b = b_i; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; busy_cnt = 0; rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    check("result_valid", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic op_res(input string tag, input logic [4:0] op_i, input logic [31:0] a_i,
                        input logic [31:0] b_i, input logic [31:0] exp);
    do_op(op_i, a_i, b_i);
    check(tag, result, exp);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {29'd0, cf, of_, zf}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // flags {cf, of, zf}
    do_op(ADD, 32'hFFFFFFFF, 32'h1);
    check("add_carry_res", result, 32'h0);
    check("add_carry_flags", {29'd0, cf, of_, zf}, 32'b101);
    check("add_lat", lat, 0);
    do_op(ADD, 32'h7FFFFFFF, 32'h1);
    check("add_ovf_res", result, 32'h80000000);
    check("add_ovf_flags", {29'd0, cf, of_, zf}, 32'b010);
    do_op(ADDU, 32'hFFFFFFFF, 32'h1);
    check("addu_flags", {29'd0, cf, of_, zf}, 32'b001);
    do_op(SUB, 32'h0, 32'h1);
    check("sub_borrow_res", result, 32'hFFFFFFFF);
    check("sub_borrow_flags", {29'd0, cf, of_, zf}, 32'b100);
    do_op(SUB, 32'h80000000, 32'h1);
    check("sub_ovf_res", result, 32'h7FFFFFFF);
    check("sub_ovf_flags", {29'd0, cf, of_, zf}, 32'b010);

    op_res("sra", SRA, 32'h00000024, 32'h80000000, 32'hF8000000);
    op_res("srl", SRL, 32'h00000024, 32'h80000000, 32'h08000000);
    op_res("sll", SLL, 32'h00000021, 32'h00000001, 32'h00000002);
    op_res("lt", LT, 32'hFFFFFFFF, 32'h1, 32'h1);
    op_res("ltu", LTU, 32'hFFFFFFFF, 32'h1, 32'h0);
    op_res("eq", EQ, 32'h5, 32'h5, 32'h1);
    op_res("ne", NE, 32'h5, 32'h5, 32'h0);
    check("ne_zf", {31'd0, zf}, 32'd1);
    op_res("nor", NOR, 32'h0, 32'h0, 32'hFFFFFFFF);
    op_res("undef_op", 5'd25, 32'h3, 32'h4, 32'h0);

    do_op(MULH, 32'h80000000, 32'h80000000);
    check("mulh_res", result, 32'h40000000);
    check("mulh_lat", lat, 33);
    check("mulh_in_ready_low", {31'd0, rdy_seen}, 32'd0);
    check("mulh_busy_cycles", busy_cnt, 33);
    check("mulh_busy_after", {31'd0, busy}, 32'd0);
    do_op(MUL, 32'h80000000, 32'h80000000);
    check("mul_res", result, 32'h0);
    check("mul_flags", {29'd0, cf, of_, zf}, 32'b001);
    op_res("mulhu", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    op_res("mul_lo", MUL, 32'hFFFFFFFF, 32'h3, 32'hFFFFFFFD);
    op_res("mulh_neg", MULH, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF);
    op_res("mul_small", MUL, 32'd1234, 32'd5678, 32'd7006652);

`ifdef MBSCORE_ALU_MDU_DIV_EN
    op_res("div_min_m1", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    check("div_lat", lat, 33);
    op_res("rem_min_m1", REM, 32'h80000000, 32'hFFFFFFFF, 32'h0);
    op_res("divu_by0", DIVU, 32'd7, 32'd0, 32'hFFFFFFFF);
    check("divu_by0_flags", {29'd0, cf, of_, zf}, 32'b000);
    op_res("remu_by0", REMU, 32'd7, 32'd0, 32'd7);
    op_res("div_neg", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    op_res("rem_neg", REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    op_res("div_neg_by0", DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF);
    op_res("rem_neg_by0", REM, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9);
    op_res("divu_big", DIVU, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF);
`else
    op_res("div_disabled", DIV, 32'd6, 32'd3, 32'h0);
    check("div_disabled_lat", lat, 0);
    check("div_disabled_busy", {31'd0, busy}, 32'd0);
    op_res("remu_disabled", REMU, 32'd7, 32'd0, 32'h0);
`endif

    // back-pressure: result held stable, no new accept
    @(posedge clk); #1;
    @(negedge clk); out_ready = 1'b0;
    do_op(ADD, 32'd2, 32'd3);
    hold_res = result;
    flag = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || result !== 32'd5 || {cf, of_, zf} !== 3'b000) flag = 1'b1;
    end
    check("stall_first", hold_res, 32'd5);
    check("stall_stable", {31'd0, flag}, 32'd0);

    // stream four ADDs at one per cycle
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; op = ADD; a = k; b = 10 * k;
      @(posedge clk); #1;
      check($sformatf("stream_res%0d", k), result, 11 * k);
      check($sformatf("stream_valid%0d", k), {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk); in_valid = 1'b0;

    // reset part-way through an iterative op
    @(negedge clk);
`ifdef MBSCORE_ALU_MDU_DIV_EN
    op = DIVU;
`else
    op = MUL;
`endif
    a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) @(posedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    flag = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) flag = 1'b1;
    end
    check("abort_no_result", {31'd0, flag}, 32'd0);
    op_res("after_abort_add", ADD, 32'd40, 32'd2, 32'd42);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
